ray_hit_resolve: RTL and testbench
==================================

# ray_hit_resolve

Sequential nearest-hit reducer directly downstream of the ray/triangle intersection stage. It consumes one intersection result per clock for a single ray tested against a stream of triangles, keeps the closest valid hit by unsigned fixed-point distance t, and emits one resolved record per ray over a valid/ready handshake. The shading and pixel-write stages consume its output.

## Interface
- WIDTH, 32, bit width of the integer part and of the fractional part of t, and of each intersection point coordinate
- ID_WIDTH, 16, triangle index width
- CNT_WIDTH, 16, width of the per-ray candidate counter
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  candidate beat present
- in_ready  out  1  block accepts a beat this cycle
- in_hit  in  1  intersection valid flag from the intersection stage
- in_t_int  in  WIDTH  integer part of t
- in_t_frac  in  WIDTH  fractional part of t
- in_o1, in_o2, in_o3  in  WIDTH each  intersection point
- in_id  in  ID_WIDTH  triangle index
- in_last  in  1  final candidate for the current ray
- out_valid  out  1  resolved record present
- out_ready  in  1  downstream accepts the record
- out_hit  out  1  at least one valid hit in the ray
- out_t_int, out_t_frac  out  WIDTH each  nearest t
- out_o1, out_o2, out_o3  out  WIDTH each  nearest intersection point
- out_id  out  ID_WIDTH  triangle index of the nearest hit
- out_count  out  CNT_WIDTH  candidates accepted for this ray, saturating

## Operation
- FSM states: ACCUM (collecting) and HOLD (record presented).
- ACCUM: in_ready=1 and out_valid=0. A beat is accepted when in_valid&&in_ready.
- Compare key: the 2·WIDTH-bit unsigned concatenation {t_int,t_frac}.
- An accepted beat with in_hit=1 replaces the best record if no hit is held yet, or if its key is strictly less than the best key. On a tie, the earlier beat is kept.
- An accepted beat with in_hit=0 never changes best_hit, t, o or id.
- Every accepted beat increments the count. The count saturates at 2^CNT_WIDTH−1.
- Accepting a beat with in_last=1 folds that beat in and moves the FSM to HOLD.
- HOLD: in_ready=0 and out_valid=1. The outputs show the final best record and count and stay stable until taken.
- A handshake (out_valid&&out_ready) clears best_hit, the key, o, id and the count to 0 and returns the FSM to ACCUM.
- When out_hit=0, out_t, out_o and out_id are all 0.
- A one-beat ray (in_last on the first beat) is legal.
- in_* values are don't-care when in_valid=0.

## Timing
- Reset: the FSM goes to ACCUM. in_ready=1 in the first cycle after reset. out_valid=0, out_hit=0, and all data outputs and out_count are 0.
- rst has priority over every other event. Asserting rst mid-ray or while in HOLD discards the partial or pending record with no output.
- State updates on the clock edge that accepts the beat. No combinational path from in_* to out_*.
- Latency: when the last beat is accepted at edge N, out_valid is 1 after edge N.
- in_ready depends only on the registered state, not on out_ready, so there are no combinational ready loops.
- Throughput: one candidate per cycle within a ray. Between rays there is at least one cycle with in_ready=0 (HOLD) for every record; HOLD lasts until out_ready.
- If out_ready is already high when HOLD is entered, the record is taken at edge N+1. The next ray's first beat can then be accepted at edge N+2.

## Test plan
- Reset release, then 4 beats (ids 0–3) with in_hit=1,1,0,1, t={5,0},{2,0x8000_0000},{1,0},{2,0x8000_0000}, and in_last on beat 3. Expected: out_valid one cycle after the last beat, out_hit=1, out_id=1, t={2,0x8000_0000}, out_count=4. The tie keeps id 1, and the miss with smaller t is ignored.
- Ray of 3 beats, all in_hit=0. Expected: out_hit=0, t=o=id=0, out_count=3.
- Hold out_ready=0 for 10 cycles in HOLD while driving in_valid=1. Expected: in_ready stays 0, outputs do not change, and no beats are lost. Raise out_ready and check a single transfer followed by ACCUM with cleared state.
- Back-to-back one-beat rays with out_ready tied to 1. Expected: beats are accepted every other cycle, one record per beat, and each record carries its own beat's id and count 1.
- Assert rst for one cycle after 2 beats of a ray, then send a new 1-beat ray with id 7 and t={3,0}. Expected: the only record seen has id 7 and count 1. Repeat with rst asserted during HOLD: no record is emitted.
- With CNT_WIDTH=2, send a 6-beat ray. Expected: out_count=3 (saturated), and the nearest hit is still resolved correctly.

Source files
------------

// File: rtl/ray_hit_resolve_if.sv
// Candidate-in / resolved-record-out bus of the nearest-hit reducer.
// slave is the reducer's view, master is the upstream/downstream view.
interface ray_hit_resolve_if #(
  parameter int WIDTH     = 32,
  parameter int ID_WIDTH  = 16,
  parameter int CNT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_hit;
  logic [WIDTH-1:0]     in_t_int;
  logic [WIDTH-1:0]     in_t_frac;
  logic [WIDTH-1:0]     in_o1;
  logic [WIDTH-1:0]     in_o2;
  logic [WIDTH-1:0]     in_o3;
  logic [ID_WIDTH-1:0]  in_id;
  logic                 in_last;

  logic                 out_valid;
  logic                 out_ready;
  logic                 out_hit;
  logic [WIDTH-1:0]     out_t_int;
  logic [WIDTH-1:0]     out_t_frac;
  logic [WIDTH-1:0]     out_o1;
  logic [WIDTH-1:0]     out_o2;
  logic [WIDTH-1:0]     out_o3;
  logic [ID_WIDTH-1:0]  out_id;
  logic [CNT_WIDTH-1:0] out_count;

  modport slave (
    input  in_valid, in_hit, in_t_int, in_t_frac, in_o1, in_o2, in_o3, in_id, in_last,
    input  out_ready,
    output in_ready,
    output out_valid, out_hit, out_t_int, out_t_frac, out_o1, out_o2, out_o3, out_id, out_count
  );

  modport master (
    output in_valid, in_hit, in_t_int, in_t_frac, in_o1, in_o2, in_o3, in_id, in_last,
    output out_ready,
    input  in_ready,
    input  out_valid, out_hit, out_t_int, out_t_frac, out_o1, out_o2, out_o3, out_id, out_count
  );
endinterface

// File: rtl/ray_hit_resolve.sv
// Nearest-hit reducer: folds one intersection candidate per clock into the
// closest valid hit of the current ray, then presents one record per ray.
module ray_hit_resolve #(
  parameter int WIDTH     = 32,
  parameter int ID_WIDTH  = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  ray_hit_resolve_if.slave  bus
);

  typedef enum logic {ACCUM, HOLD} state_t;

  // Best-so-far record; key is {t_int, t_frac} so one unsigned compare orders t.
  typedef struct packed {
    logic                 hit;
    logic [2*WIDTH-1:0]   key;
    logic [WIDTH-1:0]     o1;
    logic [WIDTH-1:0]     o2;
    logic [WIDTH-1:0]     o3;
    logic [ID_WIDTH-1:0]  id;
    logic [CNT_WIDTH-1:0] cnt;
  } rec_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  rec_t               rec_q, rec_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] in_key;
  logic               closer;

  // Next-state and record fold; ties keep the earlier beat (strict less-than).
  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    in_key  = {bus.in_t_int, bus.in_t_frac};
    closer  = !rec_q.hit || (in_key < rec_q.key);
    case (state_q)
      ACCUM: begin
        if (bus.in_valid) begin
          if (rec_q.cnt != CNT_MAX) rec_d.cnt = rec_q.cnt + 1'b1;
          if (bus.in_hit && closer) begin
            rec_d.hit = 1'b1;
            rec_d.key = in_key;
            rec_d.o1  = bus.in_o1;
            rec_d.o2  = bus.in_o2;
            rec_d.o3  = bus.in_o3;
            rec_d.id  = bus.in_id;
          end
          if (bus.in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          rec_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
    // Handshake flags come from the next state so both are plain flops.
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == HOLD);
  end

  // State, record and handshake flags; reset discards any partial or held ray.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      rec_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rec_q       <= rec_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_hit    = rec_q.hit;
  assign bus.out_t_int  = rec_q.key[2*WIDTH-1:WIDTH];
  assign bus.out_t_frac = rec_q.key[WIDTH-1:0];
  assign bus.out_o1     = rec_q.o1;
  assign bus.out_o2     = rec_q.o2;
  assign bus.out_o3     = rec_q.o3;
  assign bus.out_id     = rec_q.id;
  assign bus.out_count  = rec_q.cnt;

endmodule

// File: tb/tb_ray_hit_resolve.sv
// Bench for ray_hit_resolve: a 16-bit-count DUT and a 2-bit-count DUT share
// one stimulus stream; records from both are checked against a ray-level model.
module tb_ray_hit_resolve;
  localparam int W = 32, IW = 16, CW = 16, CW2 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ray_hit_resolve_if #(.WIDTH(W), .ID_WIDTH(IW), .CNT_WIDTH(CW))  bus ();
  ray_hit_resolve_if #(.WIDTH(W), .ID_WIDTH(IW), .CNT_WIDTH(CW2)) bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_hit    = bus.in_hit;
  assign bus2.in_t_int  = bus.in_t_int;
  assign bus2.in_t_frac = bus.in_t_frac;
  assign bus2.in_o1     = bus.in_o1;
  assign bus2.in_o2     = bus.in_o2;
  assign bus2.in_o3     = bus.in_o3;
  assign bus2.in_id     = bus.in_id;
  assign bus2.in_last   = bus.in_last;
  assign bus2.out_ready = bus.out_ready;

  ray_hit_resolve #(.WIDTH(W), .ID_WIDTH(IW), .CNT_WIDTH(CW))  dut  (.clk(clk), .rst(rst), .bus(bus));
  ray_hit_resolve #(.WIDTH(W), .ID_WIDTH(IW), .CNT_WIDTH(CW2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic hit; logic [31:0] ti, tf, o1, o2, o3; logic [15:0] id; logic last;
  } beat_t;

  typedef struct {
    logic hit; logic [31:0] ti, tf, o1, o2, o3; logic [15:0] id;
    logic [15:0] cnt; logic [1:0] cnt2; logic [15:0] id2; logic v2;
  } rec_t;

  typedef struct {
    beat_t b; logic exp_hit; logic [15:0] exp_id; logic [31:0] exp_ti, exp_tf;
    logic [15:0] exp_cnt; logic [1:0] exp_cnt2;
  } vec_t;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  rec_t  rec_q[$];
  int    acc_cyc[$];
  beat_t cur[$];
  vec_t  tbl[$];

  // Record every output transfer and every accepted input beat.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && bus.out_valid && bus.out_ready)
      rec_q.push_back('{bus.out_hit, bus.out_t_int, bus.out_t_frac, bus.out_o1, bus.out_o2,
                        bus.out_o3, bus.out_id, bus.out_count, bus2.out_count, bus2.out_id,
                        bus2.out_valid});
    if (!rst && bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic beat_t mkb(input logic hit, input logic [31:0] ti, input logic [31:0] tf,
                                input logic [15:0] id, input logic last);
    beat_t b;
    b.hit = hit; b.ti = ti; b.tf = tf; b.id = id; b.last = last;
    b.o1 = 32'h100 + 32'(id); b.o2 = 32'h200 + 32'(id); b.o3 = 32'h300 + 32'(id);
    return b;
  endfunction

  task automatic add_vec(input beat_t b, input logic eh, input logic [15:0] eid,
                         input logic [31:0] eti, input logic [31:0] etf,
                         input logic [15:0] ec, input logic [1:0] ec2);
    vec_t v;
    v.b = b; v.exp_hit = eh; v.exp_id = eid; v.exp_ti = eti; v.exp_tf = etf;
    v.exp_cnt = ec; v.exp_cnt2 = ec2;
    tbl.push_back(v);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input beat_t b);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_hit = b.hit; bus.in_t_int = b.ti; bus.in_t_frac = b.tf;
    bus.in_o1 = b.o1; bus.in_o2 = b.o2; bus.in_o3 = b.o3; bus.in_id = b.id; bus.in_last = b.last;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); @(negedge clk); n++;
    end
    if (!bus.in_ready) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_rec(input int target);
    int k = 0;
    while (rec_q.size() < target && k < 30) begin
      @(negedge clk); k++;
    end
    if (rec_q.size() < target) chk("record_timeout", 64'(rec_q.size()), 64'(target));
  endtask

  task automatic cmp_rec(input string tag, input rec_t g, input rec_t e);
    chk({tag, "_hit"}, 64'(g.hit), 64'(e.hit));
    chk({tag, "_t"}, {g.ti, g.tf}, {e.ti, e.tf});
    chk({tag, "_o"}, 64'({g.o1, g.o2} ^ 64'(g.o3)), 64'({e.o1, e.o2} ^ 64'(e.o3)));
    chk({tag, "_o3"}, 64'(g.o3), 64'(e.o3));
    chk({tag, "_id"}, 64'(g.id), 64'(e.id));
    chk({tag, "_cnt"}, 64'(g.cnt), 64'(e.cnt));
    chk({tag, "_cnt_sat"}, 64'(g.cnt2), 64'(e.cnt2));
    chk({tag, "_id_sat"}, 64'(g.id2), 64'(e.id));
    chk({tag, "_valid_sat"}, 64'(g.v2), 64'd1);
  endtask

  // Reference: nearest hit of the whole ray, earliest wins a tie; count saturates.
  function automatic rec_t model();
    rec_t e;
    int   n = 0;
    e = '{default: '0};
    foreach (cur[i]) begin
      n++;
      if (cur[i].hit && (!e.hit || {cur[i].ti, cur[i].tf} < {e.ti, e.tf})) begin
        e.hit = 1'b1; e.ti = cur[i].ti; e.tf = cur[i].tf;
        e.o1 = cur[i].o1; e.o2 = cur[i].o2; e.o3 = cur[i].o3; e.id = cur[i].id;
      end
    end
    e.cnt  = (n > 65535) ? 16'hFFFF : 16'(n);
    e.cnt2 = (n > 3) ? 2'd3 : 2'(n);
    e.v2   = 1'b1;
    return e;
  endfunction

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rec_t e;
    beat_t b;
    int n0, a0, len;

    bus.in_valid = 0; bus.in_hit = 0; bus.in_t_int = 0; bus.in_t_frac = 0;
    bus.in_o1 = 0; bus.in_o2 = 0; bus.in_o3 = 0; bus.in_id = 0; bus.in_last = 0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_hit", 64'(bus.out_hit), 64'd0);
    chk("rst_data", {bus.out_t_int, bus.out_t_frac} | 64'(bus.out_id) | 64'(bus.out_o1), 64'd0);
    chk("rst_count", 64'(bus.out_count), 64'd0);

    // Table: near hit with tie and closer miss, all-miss ray, max key, zero key, saturation.
    add_vec(mkb(1, 5, 0, 0, 0), 0, 0, 0, 0, 0, 0);
    add_vec(mkb(1, 2, 32'h8000_0000, 1, 0), 0, 0, 0, 0, 0, 0);
    add_vec(mkb(0, 1, 0, 2, 0), 0, 0, 0, 0, 0, 0);
    add_vec(mkb(1, 2, 32'h8000_0000, 3, 1), 1, 1, 2, 32'h8000_0000, 4, 3);
    add_vec(mkb(0, 0, 1, 4, 0), 0, 0, 0, 0, 0, 0);
    add_vec(mkb(0, 7, 7, 5, 0), 0, 0, 0, 0, 0, 0);
    add_vec(mkb(0, 0, 0, 6, 1), 0, 0, 0, 0, 3, 3);
    add_vec(mkb(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8, 1), 1, 8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1);
    add_vec(mkb(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 0), 0, 0, 0, 0, 0, 0);
    add_vec(mkb(1, 0, 0, 10, 1), 1, 10, 0, 0, 2, 2);
    add_vec(mkb(1, 9, 0, 40, 0), 0, 0, 0, 0, 0, 0);
    add_vec(mkb(1, 8, 0, 41, 0), 0, 0, 0, 0, 0, 0);
    add_vec(mkb(0, 1, 0, 42, 0), 0, 0, 0, 0, 0, 0);
    add_vec(mkb(1, 7, 5, 43, 0), 0, 0, 0, 0, 0, 0);
    add_vec(mkb(1, 3, 3, 44, 0), 0, 0, 0, 0, 0, 0);
    add_vec(mkb(1, 3, 3, 45, 1), 1, 44, 3, 3, 6, 3);

    foreach (tbl[i]) begin
      n0 = rec_q.size();
      send_beat(tbl[i].b);
      if (tbl[i].b.last) begin
        chk($sformatf("tbl%0d_latency", i), 64'(bus.out_valid), 64'd1);
        wait_rec(n0 + 1);
        e = '{default: '0};
        e.hit = tbl[i].exp_hit; e.ti = tbl[i].exp_ti; e.tf = tbl[i].exp_tf; e.id = tbl[i].exp_id;
        e.o1 = e.hit ? 32'h100 + 32'(e.id) : 32'h0;
        e.o2 = e.hit ? 32'h200 + 32'(e.id) : 32'h0;
        e.o3 = e.hit ? 32'h300 + 32'(e.id) : 32'h0;
        e.cnt = tbl[i].exp_cnt; e.cnt2 = tbl[i].exp_cnt2;
        if (rec_q.size() > n0) cmp_rec($sformatf("tbl%0d", i), rec_q[n0], e);
      end
    end

    // Stall in HOLD with a beat waiting upstream.
    bus.out_ready = 1'b0;
    send_beat(mkb(1, 9, 0, 20, 0));
    send_beat(mkb(1, 4, 1, 21, 1));
    b = mkb(1, 1, 0, 30, 1);
    bus.in_valid = 1'b1; bus.in_hit = b.hit; bus.in_t_int = b.ti; bus.in_t_frac = b.tf;
    bus.in_o1 = b.o1; bus.in_o2 = b.o2; bus.in_o3 = b.o3; bus.in_id = b.id; bus.in_last = 1'b1;
    n0 = rec_q.size();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_record", {bus.out_t_int, 16'(bus.out_id), 16'(bus.out_count)},
          {32'd4, 16'd21, 16'd2});
    end
    chk("stall_no_transfer", 64'(rec_q.size()), 64'(n0));
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("release_one_transfer", 64'(rec_q.size()), 64'(n0 + 1));
    if (rec_q.size() > n0) chk("release_id", 64'(rec_q[n0].id), 64'd21);
    chk("release_cleared", {63'(bus.out_count) | 63'(bus.out_id) | 63'(bus.out_t_frac), bus.out_hit}, 64'd0);
    chk("release_accum", {bus.in_ready, bus.out_valid}, 64'b10);
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    wait_rec(n0 + 2);
    if (rec_q.size() > n0 + 1)
      chk("held_beat_kept", {rec_q[n0+1].id, rec_q[n0+1].cnt}, {16'd30, 16'd1});

    // Back-to-back one-beat rays with out_ready high.
    n0 = rec_q.size(); a0 = acc_cyc.size();
    for (int i = 0; i < 5; i++) send_beat(mkb(i[0], 32'(i), 0, 16'(60 + i), 1));
    wait_rec(n0 + 5);
    for (int i = 1; i < 5; i++)
      if (acc_cyc.size() > a0 + i)
        chk("b2b_spacing", 64'(acc_cyc[a0+i] - acc_cyc[a0+i-1]), 64'd2);
    for (int i = 0; i < 5; i++)
      if (rec_q.size() > n0 + i)
        chk($sformatf("b2b_rec%0d", i), {rec_q[n0+i].hit, rec_q[n0+i].id, rec_q[n0+i].cnt},
            {i[0], i[0] ? 16'(60 + i) : 16'd0, 16'd1});

    // Reset mid-ray discards the partial ray.
    send_beat(mkb(1, 0, 0, 50, 0));
    send_beat(mkb(1, 0, 0, 51, 0));
    pulse_rst();
    n0 = rec_q.size();
    send_beat(mkb(1, 3, 0, 7, 1));
    wait_rec(n0 + 1);
    repeat (3) @(negedge clk);
    chk("rst_mid_records", 64'(rec_q.size()), 64'(n0 + 1));
    if (rec_q.size() > n0)
      chk("rst_mid_rec", {rec_q[n0].id, rec_q[n0].cnt, 14'd0, rec_q[n0].cnt2, rec_q[n0].ti[15:0]},
          {16'd7, 16'd1, 14'd0, 2'd1, 16'd3});

    // Reset while a record is held: nothing is emitted.
    bus.out_ready = 1'b0;
    send_beat(mkb(1, 2, 0, 9, 1));
    chk("hold_pending", 64'(bus.out_valid), 64'd1);
    n0 = rec_q.size();
    pulse_rst();
    chk("rst_hold_cleared", {bus.out_valid, bus.out_hit, bus.in_ready, 16'(bus.out_id)}, {3'b001, 16'd0});
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_hold_no_record", 64'(rec_q.size()), 64'(n0));

    // Random rays against the model, with random output stalls.
    for (int r = 0; r < 40; r++) begin
      len = $urandom_range(1, 8);
      cur.delete();
      for (int i = 0; i < len; i++) begin
        b.hit  = 1'($urandom_range(0, 1));
        b.ti   = $urandom_range(0, 3);
        b.tf   = $urandom_range(0, 1) ? 32'($urandom_range(0, 2)) : $urandom;
        b.o1   = $urandom; b.o2 = $urandom; b.o3 = $urandom;
        b.id   = 16'($urandom);
        b.last = (i == len - 1);
        cur.push_back(b);
      end
      n0 = rec_q.size();
      bus.out_ready = 1'($urandom_range(0, 1));
      foreach (cur[i]) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send_beat(cur[i]);
      end
      if (!bus.out_ready) begin
        repeat ($urandom_range(1, 3)) begin
          chk("rnd_hold", 64'(bus.out_valid), 64'd1);
          @(negedge clk);
        end
        bus.out_ready = 1'b1;
      end
      wait_rec(n0 + 1);
      if (rec_q.size() > n0) cmp_rec($sformatf("rnd%0d", r), rec_q[n0], model());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=done", cyc);
    $fatal(1);
  end
endmodule
